// File: rtl/ldtu_bsl_estimator.sv
// -----------------------------------------------------------------------------
// ldtu_bsl_estimator
//
// Baseline estimator for the LDTU front end. On a start request it throws away
// NSKIP settling samples, averages the next 2^LOG2_NSAMP ADC samples with
// round-half-up, clips the mean to Nbits_8 bits and presents it on BSL_VAL for
// the downstream baseline-subtraction stage.
//
// Ports
//   CLK           in   block clock, rising-edge active
//   reset         in   synchronous, active-high reset
//   start         in   one-cycle request to begin a measurement (ignored while busy)
//   abort         in   cancel a measurement in SETTLE or ACCUM
//   sample_valid  in   qualifies DATA12
//   DATA12        in   unsigned ADC sample, Nbits_12 bits
//   BSL_VAL       out  registered baseline value, Nbits_8 bits
//   bsl_valid     out  at least one measurement has completed since reset
//   busy          out  FSM is not in IDLE (registered)
//   done          out  one-cycle pulse when BSL_VAL has just been updated
//   sat           out  last completed mean exceeded 2^Nbits_8-1 and was clipped
// -----------------------------------------------------------------------------
module ldtu_bsl_estimator #(
    parameter int Nbits_12   = 12,
    parameter int Nbits_8    = 8,
    parameter int LOG2_NSAMP = 4,   // 1..8
    parameter int NSKIP      = 4    // 0..15
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                sample_valid,
    input  logic [Nbits_12-1:0] DATA12,
    output logic [Nbits_8-1:0]  BSL_VAL,
    output logic                bsl_valid,
    output logic                busy,
    output logic                done,
    output logic                sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_COMPUTE,
        S_DONE
    } state_t;

    // Sum of 2^LOG2_NSAMP samples of Nbits_12 bits fits exactly, so no overflow.
    localparam int ACC_W  = Nbits_12 + LOG2_NSAMP;
    localparam int CNT_W  = LOG2_NSAMP;
    localparam int SKIP_W = 4;
    localparam int MEAN_W = Nbits_12 + 1;

    // Sample counter wraps naturally: the last accepted sample is at count all-ones.
    localparam logic [CNT_W-1:0]  LAST_CNT  = '1;
    localparam logic [SKIP_W-1:0] LAST_SKIP = SKIP_W'(NSKIP - 1);
    // Rounding offset of one half LSB of the mean.
    localparam logic [ACC_W:0]    HALF      = {{ACC_W{1'b0}}, 1'b1} << (LOG2_NSAMP - 1);
    localparam logic [MEAN_W-1:0] MEAN_MAX  = MEAN_W'((1 << Nbits_8) - 1);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [Nbits_8-1:0]  bsl_q;
    logic                sat_q;
    logic                valid_q;
    logic                busy_q;

    logic [ACC_W:0]      rounded;
    logic [MEAN_W-1:0]   mean;
    logic                mean_ovf;

    // Mean with round-half-up: add half an output LSB, then drop LOG2_NSAMP bits.
    always_comb begin
        rounded  = {1'b0, acc_q} + HALF;
        mean     = rounded[ACC_W:LOG2_NSAMP];
        mean_ovf = (mean > MEAN_MAX);
    end

    // Next-state logic.
    // NOTE: every signal is given a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;

        unique case (state_q)
            S_IDLE: begin
                // abort is irrelevant here, so start always wins.
                if (start) begin
                    state_d = S_SETTLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    skip_d  = '0;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (NSKIP == 0) begin
                    state_d = S_ACCUM;
                end else if (sample_valid) begin
                    if (skip_q == LAST_SKIP) begin
                        state_d = S_ACCUM;
                    end else begin
                        skip_d = skip_q + SKIP_W'(1);
                    end
                end
            end

            S_ACCUM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sample_valid) begin
                    acc_d = acc_q + ACC_W'(DATA12);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_COMPUTE;
                    end
                end
            end

            // Once the sample set is complete the measurement always finishes.
            S_COMPUTE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            skip_q  <= '0;
            bsl_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            // Registered decode of the next state keeps busy glitch-free and
            // exactly aligned with state_q != S_IDLE.
            busy_q  <= (state_d != S_IDLE);

            // Result registers change only on the COMPUTE edge, so the new value
            // is visible in DONE, two cycles after the last accepted sample.
            if (state_q == S_COMPUTE) begin
                bsl_q   <= mean_ovf ? '1 : mean[Nbits_8-1:0];
                sat_q   <= mean_ovf;
                valid_q <= 1'b1;
            end
        end
    end

    assign BSL_VAL   = bsl_q;
    assign sat       = sat_q;
    assign bsl_valid = valid_q;
    assign busy      = busy_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ldtu_bsl_estimator.sv
// -----------------------------------------------------------------------------
// tb_ldtu_bsl_estimator
//
// Self-checking bench for ldtu_bsl_estimator with default parameters.
// A table of sample patterns with fixed expected results is applied first,
// then randomized sample sets are compared against an arithmetic reference
// model, followed by hand-written abort and reset sequences.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ldtu_bsl_estimator;

    localparam int NSK = 4;
    localparam int NS  = 16;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        sample_valid;
    logic [11:0] DATA12;
    logic [7:0]  BSL_VAL;
    logic        bsl_valid;
    logic        busy;
    logic        done;
    logic        sat;

    ldtu_bsl_estimator #(
        .Nbits_12  (12),
        .Nbits_8   (8),
        .LOG2_NSAMP(4),
        .NSKIP     (NSK)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sample_valid(sample_valid),
        .DATA12      (DATA12),
        .BSL_VAL     (BSL_VAL),
        .bsl_valid   (bsl_valid),
        .busy        (busy),
        .done        (done),
        .sat         (sat)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          gap;      // idle cycles before each valid sample
        logic [11:0] a;        // value of even-indexed samples
        logic [11:0] b;        // value of odd-indexed samples
        logic [7:0]  exp_bsl;
        bit          exp_sat;
        bit          stray;    // issue an extra start while busy
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] smp [NS];
    vec_t        tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Reference: plain integer average with round-half-up, then clip.
    function automatic void ref_model(output logic [7:0] b, output bit s);
        int sum;
        int m;
        sum = 0;
        for (int i = 0; i < NS; i++) sum += int'(smp[i]);
        m = (sum + NS / 2) / NS;
        if (m > 255) begin
            b = 8'hFF;
            s = 1'b1;
        end else begin
            b = 8'(m);
            s = 1'b0;
        end
    endfunction

    task automatic feed(input int gap, input logic [11:0] val);
        repeat (gap) begin
            sample_valid = 1'b0;
            DATA12       = 12'(val + 12'd1);
            tick();
        end
        sample_valid = 1'b1;
        DATA12       = val;
        tick();
        sample_valid = 1'b0;
    endtask

    // Full measurement: start, NSK discarded samples, NS samples from smp[].
    // Abort is held high through COMPUTE and DONE, where it must be ignored.
    task automatic run(input string tag, input int gap, input bit stray,
                       input logic [7:0] eb, input bit es);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < NSK; k++) feed(gap, 12'd4000);
        for (int k = 0; k < NS; k++) begin
            if (stray && k == 5) start = 1'b1;
            feed(gap, smp[k]);
            start = 1'b0;
        end
        // Cycle N+1: COMPUTE; extra valid samples here must be ignored.
        sample_valid = 1'b1;
        DATA12       = 12'd4095;
        abort        = 1'b1;
        check({tag, ".done_early"}, 32'(done), 32'd0);
        tick();
        sample_valid = 1'b0;
        // Cycle N+2: result visible with done.
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".bsl"}, 32'(BSL_VAL), 32'(eb));
        check({tag, ".sat"}, 32'(sat), 32'(es));
        check({tag, ".bsl_valid"}, 32'(bsl_valid), 32'd1);
        tick();
        abort = 1'b0;
        // Cycle N+3: back in IDLE, no queued start.
        check({tag, ".done_clr"}, 32'(done), 32'd0);
        check({tag, ".busy_clr"}, 32'(busy), 32'd0);
        check({tag, ".bsl_hold"}, 32'(BSL_VAL), 32'(eb));
    endtask

    task automatic fill(input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < NS; i++) smp[i] = (i % 2 == 0) ? a : b;
    endtask

    initial begin
        logic [7:0] eb;
        bit         es;
        int         lim;

        tbl[0] = '{gap: 0, a: 12'd100,  b: 12'd100,  exp_bsl: 8'd100, exp_sat: 1'b0, stray: 1'b0};
        tbl[1] = '{gap: 0, a: 12'd10,   b: 12'd11,   exp_bsl: 8'd11,  exp_sat: 1'b0, stray: 1'b0};
        tbl[2] = '{gap: 0, a: 12'd10,   b: 12'd10,   exp_bsl: 8'd10,  exp_sat: 1'b0, stray: 1'b0};
        tbl[3] = '{gap: 0, a: 12'd4095, b: 12'd4095, exp_bsl: 8'd255, exp_sat: 1'b1, stray: 1'b0};
        tbl[4] = '{gap: 0, a: 12'd255,  b: 12'd255,  exp_bsl: 8'd255, exp_sat: 1'b0, stray: 1'b0};
        tbl[5] = '{gap: 0, a: 12'd255,  b: 12'd256,  exp_bsl: 8'd255, exp_sat: 1'b1, stray: 1'b0};
        tbl[6] = '{gap: 2, a: 12'd100,  b: 12'd100,  exp_bsl: 8'd100, exp_sat: 1'b0, stray: 1'b1};

        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        DATA12       = '0;
        repeat (3) tick();
        // Reset must win over start.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst.bsl", 32'(BSL_VAL), 32'd0);
        check("rst.bsl_valid", 32'(bsl_valid), 32'd0);
        check("rst.sat", 32'(sat), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            fill(tbl[i].a, tbl[i].b);
            run($sformatf("vec%0d", i), tbl[i].gap, tbl[i].stray, tbl[i].exp_bsl, tbl[i].exp_sat);
        end

        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                0:       lim = 300;
                1:       lim = 4095;
                default: lim = 40;
            endcase
            for (int i = 0; i < NS; i++) smp[i] = 12'($urandom_range(0, lim));
            ref_model(eb, es);
            run($sformatf("rnd%0d", r), int'($urandom_range(0, 2)), 1'b0, eb, es);
        end

        // Abort after 7 accumulated samples.
        fill(12'd100, 12'd100);
        run("pre_abort", 0, 1'b0, 8'd100, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NSK; k++) feed(0, 12'd4000);
        for (int k = 0; k < 7; k++) feed(0, 12'd3000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("abort.no_done", 32'(done), 32'd0);
            tick();
        end
        check("abort.bsl", 32'(BSL_VAL), 32'd100);
        check("abort.bsl_valid", 32'(bsl_valid), 32'd1);
        fill(12'd10, 12'd10);
        run("post_abort", 0, 1'b0, 8'd10, 1'b0);

        // Reset in ACCUM after a completed run.
        fill(12'd100, 12'd100);
        run("pre_reset", 0, 1'b0, 8'd100, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NSK; k++) feed(0, 12'd4000);
        for (int k = 0; k < 3; k++) feed(0, 12'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst.bsl", 32'(BSL_VAL), 32'd0);
        check("mid_rst.bsl_valid", 32'(bsl_valid), 32'd0);
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.done", 32'(done), 32'd0);
        // Start in the first cycle after reset deasserts, no samples follow.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("settle_hold.busy", 32'(busy), 32'd1);
            check("settle_hold.done", 32'(done), 32'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("settle_abort.busy", 32'(busy), 32'd0);
        check("settle_abort.bsl_valid", 32'(bsl_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
